// File: rtl/note_scheduler_pkg.sv
// rtl/note_scheduler_pkg.sv - shared state enum and default sizing for the note scheduler
package note_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LANES_DEF = 4;
  localparam int DEPTH_DEF = 64;
  localparam int TICKS_DEF = 4;
  localparam int ADDR_W    = $clog2(DEPTH_DEF);
  localparam int LEN_W     = ADDR_W + 1;

endpackage

// File: rtl/note_scheduler_if.sv
// rtl/note_scheduler_if.sv - control, chart-write and strobe bundle of the note scheduler
interface note_scheduler_if import note_sched_pkg::*; #(
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          start;
  logic          pause;
  logic [LW-1:0] len;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [LANES-1:0] wr_data;
  logic [LANES-1:0] map;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;

  // Game control / chart loader side
  modport master (
    output start, pause, len, wr_en, wr_addr, wr_data,
    input  map, busy, done, step_idx
  );

  // Scheduler side
  modport slave (
    input  start, pause, len, wr_en, wr_addr, wr_data,
    output map, busy, done, step_idx
  );

endinterface

// File: rtl/note_scheduler_tempo_divider.sv
// rtl/note_scheduler_tempo_divider.sv - tick counter producing one terminal pulse per chart step
module tempo_divider #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic terminal
);

  localparam int TW = $clog2(TICKS);
  localparam logic [TW-1:0] LAST = TW'(TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;

  // Clear restarts the step; hold freezes the tick (idle or paused)
  always_comb begin
    tick_d = tick_q;
    if (clear) begin
      tick_d = '0;
    end else if (!hold) begin
      tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
    end
  end

  // Tick register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end

  assign terminal = !clear && !hold && (tick_q == LAST);

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - chart sequencer issuing per-lane spawn strobes; NOTE_SCHED_LOOP_EN enables endless looping
module note_scheduler import note_sched_pkg::*; #(
  parameter int LANES          = LANES_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int TICKS_PER_STEP = TICKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  note_scheduler_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LANES-1:0] map_q, map_d;
  logic [LANES-1:0] chart_q [DEPTH];

  logic idle_or_done;
  logic start_ok;
  logic active;
  logic fire;
  logic last_step;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok     = idle_or_done && bus.start;
  // A PAUSE cycle with pause released behaves like a RUN cycle, so a pause of P cycles delays by exactly P
  assign active       = !idle_or_done && !bus.pause;
  assign last_step    = ({1'b0, step_q} == (len_q - LW'(1)));

  tempo_divider #(.TICKS(TICKS_PER_STEP)) u_tempo (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .hold     (!active),
    .terminal (fire)
  );

  // Chart storage; only writable while not playing
  always_ff @(posedge clk) begin
    if (bus.wr_en && idle_or_done) chart_q[bus.wr_addr] <= bus.wr_data;
  end

  // Playback sequencing: next state, step advance and strobe selection
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    map_d   = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          len_d   = bus.len;
          step_d  = '0;
          state_d = (bus.len == '0) ? ST_DONE : ST_RUN;
        end
      end
      default: begin
        if (bus.pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (fire) begin
            map_d  = chart_q[step_q];
            step_d = step_q + 1'b1;
            if (last_step) begin
`ifdef NOTE_SCHED_LOOP_EN
              step_d = '0;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
      end
    endcase
  end

  // Playback state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      map_q   <= map_d;
    end
  end

  assign bus.map      = map_q;
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.step_idx = step_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - directed self-checking bench for note_scheduler
module tb_note_scheduler;
  import note_sched_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  note_scheduler_if #(.LANES(LANES_DEF), .DEPTH(DEPTH_DEF)) bus ();

  note_scheduler #(.LANES(LANES_DEF), .DEPTH(DEPTH_DEF), .TICKS_PER_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_chart(input logic [ADDR_W-1:0] addr, input logic [3:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Returns at the falling edge right after start-sampling edge N
  task automatic do_start(input logic [LEN_W-1:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.len = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.map !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: map=%b busy=%b done=%b step=%0d, required all zero",
               bus.map, bus.busy, bus.done, bus.step_idx);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_map;
    logic [5:0] exp_step;
    write_chart(6'd0, 4'b0001);
    write_chart(6'd1, 4'b0110);
    write_chart(6'd2, 4'b1111);
    do_start(7'd3);
    checks++;
    if (bus.busy !== 1'b1 || bus.step_idx !== 6'd0) begin
      errors++;
      $display("FAIL basic_start: busy=%b step=%0d, required busy=1 step=0", bus.busy, bus.step_idx);
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_map  = (k == 4) ? 4'b0001 : (k == 8) ? 4'b0110 : (k == 12) ? 4'b1111 : 4'b0000;
      exp_step = (k >= 12) ? 6'd3 : 6'(k / 4);
      checks++;
      if (bus.map !== exp_map) begin
        errors++;
        $display("FAIL basic_map k=%0d: got %b, required %b", k, bus.map, exp_map);
      end
      checks++;
      if (bus.done !== (k >= 12) || bus.busy !== (k < 12)) begin
        errors++;
        $display("FAIL basic_flags k=%0d: done=%b busy=%b, required done=%b", k, bus.done, bus.busy, k >= 12);
      end
      checks++;
      if (bus.step_idx !== exp_step) begin
        errors++;
        $display("FAIL basic_step k=%0d: got %0d, required %0d", k, bus.step_idx, exp_step);
      end
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp_map;
    do_start(7'd3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_map = (k == 4) ? 4'b0001 : (k == 13) ? 4'b0110 : (k == 17) ? 4'b1111 : 4'b0000;
      checks++;
      if (bus.map !== exp_map) begin
        errors++;
        $display("FAIL pause_map k=%0d: got %b, required %b", k, bus.map, exp_map);
      end
      checks++;
      if (bus.done !== (k >= 17)) begin
        errors++;
        $display("FAIL pause_done k=%0d: got %b, required %b", k, bus.done, k >= 17);
      end
      if (k >= 5 && k <= 9) begin
        checks++;
        if (bus.step_idx !== 6'd1 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL pause_hold k=%0d: step=%0d busy=%b, required step=1 busy=1", k, bus.step_idx, bus.busy);
        end
      end
      bus.pause = (k >= 4 && k < 9);
    end
  endtask

  task automatic test_write_ignored();
    do_start(7'd3);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 8) begin
        checks++;
        if (bus.map !== 4'b0110) begin
          errors++;
          $display("FAIL run_write_ignored: got %b, required 0110", bus.map);
        end
      end
      bus.wr_en = (k == 1); bus.wr_addr = 6'd1; bus.wr_data = 4'b1000;
    end
    bus.wr_en = 1'b0;
    write_chart(6'd1, 4'b1000);
    do_start(7'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4 || k == 8) begin
        checks++;
        if (bus.map !== ((k == 4) ? 4'b0001 : 4'b1000)) begin
          errors++;
          $display("FAIL rewrite_map k=%0d: got %b, required %b", k, bus.map, (k == 4) ? 4'b0001 : 4'b1000);
        end
      end
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL rewrite_done: got %b, required 1", bus.done);
    end
  endtask

  task automatic test_reset_mid();
    do_start(7'd3);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.map !== 4'b0001) begin
      errors++;
      $display("FAIL mid_before_reset: map=%b, required 0001", bus.map);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.map !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.step_idx !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: map=%b busy=%b done=%b step=%0d, required all zero",
               bus.map, bus.busy, bus.done, bus.step_idx);
    end
    @(negedge clk);
    reset = 1'b0;
    do_start(7'd3);
    checks++;
    if (bus.busy !== 1'b1 || bus.step_idx !== 6'd0) begin
      errors++;
      $display("FAIL restart: busy=%b step=%0d, required busy=1 step=0", bus.busy, bus.step_idx);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.map !== 4'b0001) begin
      errors++;
      $display("FAIL restart_first: map=%b, required 0001", bus.map);
    end
    pulse_reset();
  endtask

  task automatic test_zero_len();
    pulse_reset();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: done=%b, required 0", bus.done);
    end
    do_start(7'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b, required done=1 busy=0", bus.done, bus.busy);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.map !== 4'd0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_quiet k=%0d: map=%b busy=%b, required 0", k, bus.map, bus.busy);
      end
    end
  endtask

`ifdef NOTE_SCHED_LOOP_EN
  task automatic test_loop();
    logic [3:0] exp_map;
    write_chart(6'd0, 4'b0001);
    write_chart(6'd1, 4'b0010);
    do_start(7'd2);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_map = (k % 4 != 0) ? 4'b0000 : (((k / 4) % 2 == 1) ? 4'b0001 : 4'b0010);
      checks++;
      if (bus.map !== exp_map || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL loop k=%0d: map=%b done=%b, required map=%b done=0", k, bus.map, bus.done, exp_map);
      end
    end
    pulse_reset();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0; bus.pause = 1'b0; bus.len = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    test_reset();
`ifdef NOTE_SCHED_LOOP_EN
    test_loop();
    test_zero_len();
    test_reset_mid();
`else
    test_basic();
    test_pause();
    test_write_ignored();
    test_reset_mid();
    test_zero_len();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sequences note spawning for the lane note generators. It steps through a small programmable chart at a fixed tempo and issues one-cycle `map` strobes to the per-lane generators, so that each lane's position/data counter advances only on its scheduled beats. It sits between the game-control FSM (start/pause) and the bank of per-lane generators.

## Interface
- `LANES`, 4, number of lanes; width of chart entries and `map`
- `DEPTH`, 64, chart entries; must be a power of two
- `TICKS_PER_STEP`, 4, clock cycles per chart step; must be ≥2
- `clk` in 1: the single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: level; begins playback when sampled in IDLE or DONE
- `pause` in 1: level; freezes playback while high in RUN
- `len` in log2(DEPTH)+1: number of chart steps to play, 0..DEPTH; sampled at start
- `wr_en` in 1: chart write strobe
- `wr_addr` in log2(DEPTH): chart write address
- `wr_data` in LANES: lane mask for that step
- `map` out LANES: one-cycle per-lane spawn strobes
- `busy` out 1: high in RUN and PAUSE
- `done` out 1: high in DONE
- `step_idx` out log2(DEPTH): index of the next step to fire

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset value: IDLE; all outputs 0; tick counter and step index 0; chart contents undefined; no reset of the chart array is required.
- IDLE/DONE with `start`=1: latch `len`. If `len`=0, go to DONE with no strobes. Otherwise go to RUN with tick=0 and step=0.
- RUN: tick increments each cycle. When tick==TICKS_PER_STEP-1:
  - tick wraps to 0;
  - `map` ← chart[step] for exactly one cycle;
  - step increments.
- If the fired step was `len`-1, go to DONE on the same edge.
- RUN with `pause`=1: go to PAUSE. Tick and step hold; no strobe is issued in that cycle, and pause wins over a terminal tick.
- PAUSE with `pause`=0: return to RUN and resume from the held tick.
- `start` in RUN or PAUSE is ignored.
- Chart writes are accepted only in IDLE and DONE. They are ignored in RUN and PAUSE.
- An all-zero chart entry consumes a step and produces no strobes.
- `map` is 0 in every cycle without a firing step.

## Timing
- `start` sampled at edge N → RUN from edge N. Step k (0-based) fires `map` at edge N+(k+1)·TICKS_PER_STEP, and `map` stays high for one cycle.
- `done` rises at the same edge as the last strobe. `busy` falls at that edge.
- A write at edge M is readable by a playback started at edge M+1 or later.
- A pause of P cycles delays every later strobe by exactly P cycles.
- `reset` asserted mid-playback: `map`, `busy`, `done` and `step_idx` go to 0 immediately, without waiting for a clock edge.

## Configuration
- `NOTE_SCHED_LOOP_EN` defined: after step `len`-1 fires, step wraps to 0 and the block stays in RUN. DONE is reached only from IDLE with `len`=0. Playback otherwise continues until `reset`.
- `NOTE_SCHED_LOOP_EN` undefined: behaviour is as described in Operation, and playback ends in DONE.

## Structure
- Shared package `note_sched_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the default LANES/DEPTH constants;
  - the derived address and length widths.
- Sub-module `tempo_divider` holds the tick counter. Inputs: `clk`, `reset`, `clear`, `hold`. Output: a terminal-tick pulse.
- The chart is a register array inside `note_scheduler`.

## Test plan
- TICKS=4, len=3, chart {0001, 0110, 1111}, start at edge N → `map` = 0001, 0110, 1111 at N+4, N+8, N+12; `done`=1 from N+12; no other strobes.
- Same chart; `pause` high for 5 cycles starting at N+5 → strobes at N+13 and N+17; `step_idx` holds at 1 during the pause.
- len=0, start → DONE next edge; `map` never asserts; `busy` stays 0.
- Write 1000 to addr 1 during RUN → ignored. After DONE, rewrite addr 1 and restart → new value 1000 appears on the second strobe.
- `reset` pulsed at N+6 during playback → outputs 0 asynchronously, IDLE; a new start replays from step 0.
- `NOTE_SCHED_LOOP_EN` defined, len=2, chart {0001, 0010} → pattern 0001, 0010, 0001, 0010 every 4 cycles; `done` stays 0.
